seven_segment_value_loader: RTL and testbench

//  Sequencer feeding the 3-digit seven-segment display controller. Accepts a binary

---
 rtl/seven_segment_value_loader.sv | 130 +++++++++++++
 tb/tb_seven_segment_value_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_value_loader.sv
// Loads a binary value into the three seven-segment digit registers.
// The value is converted to BCD by serial double-dabble and committed only on a scan-frame tick.
module seven_segment_value_loader #(
  parameter int         BIN_WIDTH     = 10,
  parameter bit         BLANK_LEADING = 1'b1,
  parameter logic [3:0] BLANK_CODE    = 4'hF,
  parameter logic [3:0] ERR_CODE      = 4'hE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] in_value,
  input  logic                 frame_tick,
  output logic [3:0]           led1_display_value,
  output logic [3:0]           led2_display_value,
  output logic [3:0]           led3_display_value,
  output logic                 busy,
  output logic                 overflow
);

  localparam logic [3:0] LEAD_RST = BLANK_LEADING ? BLANK_CODE : 4'h0;
  localparam logic [4:0] LAST_BIT = 5'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT_FRAME} state_t;

  state_t                state_q, state_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic [19:0]           bcd_q, bcd_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [3:0]            led1_q, led1_d, led2_q, led2_d, led3_q, led3_d;
  logic                  overflow_q, overflow_d;

  logic [19:0] adj;
  logic [16:0] in_ext;
  logic [3:0]  hund, tens, units;

  assign in_ext = 17'(in_value);
  assign hund   = bcd_q[11:8];
  assign tens   = bcd_q[7:4];
  assign units  = bcd_q[3:0];

  assign in_ready           = (state_q == IDLE);
  assign busy               = ~in_ready;
  assign overflow           = overflow_q;
  assign led1_display_value = led1_q;
  assign led2_display_value = led2_q;
  assign led3_display_value = led3_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    led1_d     = led1_q;
    led2_d     = led2_q;
    led3_d     = led3_q;
    overflow_d = overflow_q;

    // Double-dabble correction: any nibble >= 5 would carry wrongly after the shift.
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_value;
          ovf_pend_d = (in_ext > 17'd999);
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {adj[18:0], bin_q[BIN_WIDTH-1]};
        bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_BIT) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_tick) begin
          overflow_d = ovf_pend_q;
          state_d    = IDLE;
          if (ovf_pend_q) begin
            led1_d = ERR_CODE;
            led2_d = ERR_CODE;
            led3_d = ERR_CODE;
          end else begin
            led1_d = (BLANK_LEADING && hund == 4'h0) ? BLANK_CODE : hund;
            led2_d = (BLANK_LEADING && hund == 4'h0 && tens == 4'h0) ? BLANK_CODE : tens;
            led3_d = units;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      led1_q     <= LEAD_RST;
      led2_q     <= LEAD_RST;
      led3_q     <= 4'h0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      led1_q     <= led1_d;
      led2_q     <= led2_d;
      led3_q     <= led3_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_value_loader.sv
// Directed bench for seven_segment_value_loader: two instances (leading blanking on/off)
// share stimulus; a scoreboard queue holds expected digits until the commit edge.
module tb_seven_segment_value_loader;

  localparam int BW = 10;

  typedef struct packed {
    logic [3:0] b1, b2, b3;
    logic [3:0] z1, z2, z3;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, frame_tick;
  logic [BW-1:0] in_value;
  logic in_ready_b, busy_b, ovf_b, in_ready_z, busy_z, ovf_z;
  logic [3:0] b1, b2, b3, z1, z2, z3;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  seven_segment_value_loader #(.BIN_WIDTH(BW), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_value(in_value), .frame_tick(frame_tick),
    .led1_display_value(b1), .led2_display_value(b2), .led3_display_value(b3),
    .busy(busy_b), .overflow(ovf_b)
  );

  seven_segment_value_loader #(.BIN_WIDTH(BW), .BLANK_LEADING(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_value(in_value), .frame_tick(frame_tick),
    .led1_display_value(z1), .led2_display_value(z2), .led3_display_value(z3),
    .busy(busy_z), .overflow(ovf_z)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int h, t, u;
    if (v > 999) begin
      e = '{b1: 4'hE, b2: 4'hE, b3: 4'hE, z1: 4'hE, z2: 4'hE, z3: 4'hE, ovf: 1'b1};
    end else begin
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      e.z1 = 4'(h);
      e.z2 = 4'(t);
      e.z3 = 4'(u);
      e.b1 = (h == 0) ? 4'hF : 4'(h);
      e.b2 = (h == 0 && t == 0) ? 4'hF : 4'(t);
      e.b3 = 4'(u);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t reset_exp();
    return '{b1: 4'hF, b2: 4'hF, b3: 4'h0, z1: 4'h0, z2: 4'h0, z3: 4'h0, ovf: 1'b0};
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, "_b1"}, 16'(b1), 16'(e.b1));
    check({tag, "_b2"}, 16'(b2), 16'(e.b2));
    check({tag, "_b3"}, 16'(b3), 16'(e.b3));
    check({tag, "_z1"}, 16'(z1), 16'(e.z1));
    check({tag, "_z2"}, 16'(z2), 16'(e.z2));
    check({tag, "_z3"}, 16'(z3), 16'(e.z3));
    check({tag, "_ovf_b"}, 16'(ovf_b), 16'(e.ovf));
    check({tag, "_ovf_z"}, 16'(ovf_z), 16'(e.ovf));
  endtask

  task automatic wait_ready(input string tag);
    int budget = 50;
    while (!in_ready_b && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_ready_timeout"}, 16'(in_ready_b), 16'd1);
  endtask

  // Presents v for one cycle while the block is ready; the accept edge is the step() here.
  task automatic accept(input int v, input string tag);
    wait_ready(tag);
    in_valid = 1'b1;
    in_value = BW'(v);
    step();
    in_valid = 1'b0;
    sb.push_back(model(v));
  endtask

  task automatic commit(input string tag);
    exp_t e;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
    end else begin
      e = sb.pop_front();
      compare_outputs(tag, e);
      last_exp = e;
    end
    check({tag, "_ready_after"}, 16'(in_ready_b), 16'd1);
  endtask

  task automatic run_value(input int v, input string tag);
    accept(v, tag);
    repeat (BW) step();
    commit(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    frame_tick = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    last_exp = reset_exp();
    compare_outputs("reset", last_exp);
    check("reset_ready", 16'(in_ready_b), 16'd1);
    check("reset_busy", 16'(busy_b), 16'd0);
    check("reset_ready_z", 16'(in_ready_z), 16'd1);

    // 123: no tick in the first WAIT_FRAME cycle, commit on edge T+12.
    accept(123, "v123");
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("v123_busy_t%0d", k + 1), 16'(in_ready_b), 16'd0);
      check($sformatf("v123_hold_t%0d", k + 1), 16'(b1), 16'(last_exp.b1));
    end
    check("v123_busy_flag", 16'(busy_b), 16'd1);
    commit("v123");

    run_value(7, "v7");
    run_value(40, "v40");
    run_value(0, "v0");
    run_value(1000, "v1000");
    run_value(1023, "v1023");
    run_value(999, "v999");

    // Ticks during CONVERT (including its last edge) are ignored; in_valid held high throughout.
    wait_ready("v456");
    in_valid = 1'b1;
    in_value = BW'(456);
    step();
    sb.push_back(model(456));
    repeat (4) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("tick_t5_b3", 16'(b3), 16'(last_exp.b3));
    repeat (4) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("tick_t10_b3", 16'(b3), 16'(last_exp.b3));
    check("tick_t10_z1", 16'(z1), 16'(last_exp.z1));
    check("tick_t10_busy", 16'(in_ready_b), 16'd0);
    commit("v456");
    in_value = BW'(789);
    step();
    sb.push_back(model(789));
    in_valid = 1'b0;
    check("v789_taken", 16'(in_ready_b), 16'd0);
    repeat (BW) step();
    commit("v789");
    step();
    check("v789_no_dup", 16'(in_ready_b), 16'd1);

    // Reset during CONVERT discards 321; a later tick must not commit anything.
    accept(321, "v321");
    sb.delete();
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    compare_outputs("midreset", reset_exp());
    check("midreset_ready", 16'(in_ready_b), 16'd1);
    check("midreset_busy", 16'(busy_b), 16'd0);
    repeat (12) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    compare_outputs("late_tick", reset_exp());
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
